// File: rtl/out_port_arb_pkg.sv
// Shared node definitions: port directions, port count and small grant helpers
// used by the output-port arbiter and its round-robin picker.
package out_port_arb_pkg;

  localparam int NUM_PORTS = 5;

  localparam logic [2:0] DIR_N = 3'd0;
  localparam logic [2:0] DIR_W = 3'd1;
  localparam logic [2:0] DIR_S = 3'd2;
  localparam logic [2:0] DIR_E = 3'd3;
  localparam logic [2:0] DIR_B = 3'd4;

  function automatic logic [2:0] onehot_to_idx(input logic [NUM_PORTS-1:0] vec);
    logic [2:0] idx;
    idx = DIR_N;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (vec[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  // Pointer moves just past the winner so it gets the lowest priority next time.
  function automatic logic [2:0] next_rr(input logic [2:0] idx);
    return (idx == DIR_B) ? DIR_N : idx + 3'd1;
  endfunction

endpackage

// File: rtl/out_port_arb_rr_arb5.sv
// Five-way rotating-priority picker: first requester found searching upward
// from ptr (modulo 5) wins; en low forces an all-zero grant.
module rr_arb5
  import out_port_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [2:0]           ptr,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] gnt
);

  logic       found;
  logic [2:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = DIR_N;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = 3'((int'(ptr) + k) % NUM_PORTS);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_port_arb.sv
// Output port: round-robin arbitration of five input buffers into a small
// output FIFO draining to the link. Define OUT_PORT_ARB_FLIT_CNT_EN for flit_cnt.
module out_port_arb
  import out_port_arb_pkg::*;
#(
  parameter int PYLD_W = 23,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          arb_req,
  input  logic [NUM_PORTS*PYLD_W-1:0]   payload_in,
  input  logic                          pg_en,
  output logic [NUM_PORTS-1:0]          arb_gnt,
  output logic                          obuf_rdy,
  output logic                          link_vld,
  input  logic                          link_rdy,
  output logic [PYLD_W-1:0]             link_pyld
`ifdef OUT_PORT_ARB_FLIT_CNT_EN
  ,output logic [15:0]                  flit_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [2:0]        rr_ptr;
  logic [PYLD_W-1:0] mem [DEPTH];
  logic              push;
  logic              pop;
  logic [2:0]        gnt_idx;

  rr_arb5 u_rr_arb5 (
    .req (arb_req),
    .ptr (rr_ptr),
    .en  (~pg_en),
    .gnt (arb_gnt)
  );

  // Readiness looks only at the current count, so a full FIFO never bypasses a pop.
  assign obuf_rdy  = (count < CNT_W'(DEPTH)) & ~pg_en;
  assign push      = (|arb_gnt) & obuf_rdy;
  assign link_vld  = (count != '0);
  assign pop       = link_vld & link_rdy;
  assign gnt_idx   = onehot_to_idx(arb_gnt);
  assign link_pyld = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      rr_ptr <= DIR_N;
    end else begin
      if (push) begin
        tail   <= (tail == LAST_SLOT) ? '0 : tail + 1'b1;
        rr_ptr <= next_rr(gnt_idx);
      end
      if (pop) begin
        head <= (head == LAST_SLOT) ? '0 : head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[tail] <= payload_in[int'(gnt_idx)*PYLD_W +: PYLD_W];
    end
  end

`ifdef OUT_PORT_ARB_FLIT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_cnt <= '0;
    end else if (pop && flit_cnt != 16'hFFFF) begin
      flit_cnt <= flit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_out_port_arb.sv
// Bench for out_port_arb: directed scenarios plus random traffic compared
// against a queue-based reference model. Honours OUT_PORT_ARB_FLIT_CNT_EN.
module tb_out_port_arb;

  localparam int PYLD_W = 23;
  localparam int DEPTH  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [4:0]            arb_req;
  logic [5*PYLD_W-1:0]   payload_in;
  logic                  pg_en;
  logic [4:0]            arb_gnt;
  logic                  obuf_rdy;
  logic                  link_vld;
  logic                  link_rdy;
  logic [PYLD_W-1:0]     link_pyld;
`ifdef OUT_PORT_ARB_FLIT_CNT_EN
  logic [15:0]           flit_cnt;
`endif

  out_port_arb #(.PYLD_W(PYLD_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .arb_req    (arb_req),
    .payload_in (payload_in),
    .pg_en      (pg_en),
    .arb_gnt    (arb_gnt),
    .obuf_rdy   (obuf_rdy),
    .link_vld   (link_vld),
    .link_rdy   (link_rdy),
    .link_pyld  (link_pyld)
`ifdef OUT_PORT_ARB_FLIT_CNT_EN
    ,.flit_cnt  (flit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [PYLD_W-1:0] modelQ[$];
  int                modelRr = 0;
  int                modelFlits = 0;

  // Last observed outputs, for directed expectations
  logic [4:0] obsGnt;
  logic       obsRdy;
  logic       obsVld;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  function automatic logic [4:0] expectGrant(input logic [4:0] req, input bit pg, input int rr);
    logic [4:0] g;
    g = '0;
    if (!pg) begin
      for (int k = 0; k < 5; k++) begin
        if (g == '0 && req[(rr + k) % 5]) g[(rr + k) % 5] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [5*PYLD_W-1:0] randPayload();
    logic [5*PYLD_W-1:0] p;
    for (int i = 0; i < 5; i++) p[i*PYLD_W +: PYLD_W] = PYLD_W'($urandom);
    return p;
  endfunction

  // One cycle: drive, check combinational/registered outputs, clock, update model.
  task automatic applyStimulus(input bit r, input logic [4:0] req, input bit pg, input bit rdy);
    logic [4:0] eg;
    bit         eRdy, eVld, doPush, doPop;
    int         win;
    @(negedge clk);
    rst        = r;
    arb_req    = req;
    pg_en      = pg;
    link_rdy   = rdy;
    payload_in = randPayload();
    #1;
    eg   = expectGrant(req, pg, modelRr);
    eRdy = (modelQ.size() < DEPTH) && !pg;
    eVld = (modelQ.size() != 0);
    obsGnt = arb_gnt;
    obsRdy = obuf_rdy;
    obsVld = link_vld;
    checkOutput("arb_gnt", 64'(arb_gnt), 64'(eg));
    checkOutput("obuf_rdy", 64'(obuf_rdy), 64'(eRdy));
    checkOutput("link_vld", 64'(link_vld), 64'(eVld));
    if (eVld) checkOutput("link_pyld", 64'(link_pyld), 64'(modelQ[0]));
`ifdef OUT_PORT_ARB_FLIT_CNT_EN
    checkOutput("flit_cnt", 64'(flit_cnt), 64'(modelFlits));
`endif
    doPush = (eg != '0) && eRdy;
    doPop  = eVld && rdy;
    win = 0;
    for (int k = 0; k < 5; k++) if (eg[k]) win = k;
    @(posedge clk);
    if (r) begin
      modelQ.delete();
      modelRr = 0;
      modelFlits = 0;
    end else begin
      if (doPop) begin
        void'(modelQ.pop_front());
        if (modelFlits < 65535) modelFlits++;
      end
      if (doPush) begin
        modelQ.push_back(payload_in[win*PYLD_W +: PYLD_W]);
        modelRr = (win + 1) % 5;
      end
    end
  endtask

  initial begin
    logic [4:0] seq [5];
    seq = '{5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00100};
    rst = 1'b1; arb_req = '0; pg_en = 1'b0; link_rdy = 1'b0; payload_in = '0;

    applyStimulus(1, 5'b00000, 0, 0);
    applyStimulus(1, 5'b00000, 0, 0);
    applyStimulus(0, 5'b00000, 0, 0);
    checkOutput("reset_vld", 64'(obsVld), 64'(0));
    checkOutput("reset_rdy", 64'(obsRdy), 64'(1));

    // Rotating grants 0,2,4,0,2 with steady request 10101
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 5'b10101, 0, 1);
      checkOutput($sformatf("rr_seq%0d", i), 64'(obsGnt), 64'(seq[i]));
    end

    // Fill with link stalled, then full: grant shown, no readiness
    applyStimulus(1, 5'b00000, 0, 0);
    applyStimulus(0, 5'b00010, 0, 0);
    applyStimulus(0, 5'b00010, 0, 0);
    applyStimulus(0, 5'b00010, 0, 0);
    checkOutput("full_rdy", 64'(obsRdy), 64'(0));
    checkOutput("full_gnt", 64'(obsGnt), 64'(5'b00010));

    // Full with link ready: pop only, push follows next cycle
    applyStimulus(0, 5'b00001, 0, 1);
    checkOutput("nobypass_rdy", 64'(obsRdy), 64'(0));
    applyStimulus(0, 5'b00001, 0, 0);
    checkOutput("after_pop_rdy", 64'(obsRdy), 64'(1));
    checkOutput("after_pop_gnt", 64'(obsGnt), 64'(5'b00001));

    // Power gating drains two flits then goes idle
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 5'b11111, 1, 1);
      checkOutput("pg_gnt", 64'(obsGnt), 64'(0));
      checkOutput("pg_vld", 64'(obsVld), 64'(1));
    end
    applyStimulus(0, 5'b11111, 1, 1);
    checkOutput("pg_empty_vld", 64'(obsVld), 64'(0));

    // Reset mid-transfer discards contents and restores pointer
    applyStimulus(0, 5'b01000, 0, 0);
    applyStimulus(1, 5'b01000, 0, 1);
    applyStimulus(0, 5'b11111, 0, 0);
    checkOutput("rst_mid_vld", 64'(obsVld), 64'(0));
    checkOutput("rst_mid_gnt", 64'(obsGnt), 64'(5'b00001));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(63) == 0), 5'($urandom),
                    ($urandom_range(7) == 0), 1'($urandom));
    end

`ifdef OUT_PORT_ARB_FLIT_CNT_EN
    applyStimulus(1, 5'b00000, 0, 0);
    for (int i = 0; i < 65545; i++) applyStimulus(0, 5'b00001, 0, 1);
    applyStimulus(0, 5'b00000, 0, 0);
    checkOutput("flit_cnt_sat", 64'(flit_cnt), 64'(16'hFFFF));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
